mesh_wormhole_packetizer: RTL and testbench
===========================================

MESH_WORMHOLE_PACKETIZER -- requirements
Module: mesh_wormhole_packetizer

Interface
REQ-001 SHALL have parameter ROW_N, default 3, mesh row count (>=2).
REQ-002 SHALL have parameter COL_M, default 3, mesh column count (>=2).
REQ-003 SHALL have parameter CHANNEL_W, default 8, flit width.
REQ-004 SHALL have parameter FLIT_ID_W, default 2, flit-type field width (constant).
REQ-005 SHALL have parameter LEN_W, default 4, payload-length field width.
REQ-006 SHALL have derived widths: FLIT_DATA_W=CHANNEL_W-FLIT_ID_W, ROW_ADDR_W=$clog2(ROW_N), COL_ADDR_W=$clog2(COL_M), with FLIT_DATA_W>=ROW_ADDR_W+COL_ADDR_W.
REQ-007 SHALL have ports:
  clk_i  input  1  single clock, rising edge.
  rst_ni  input  1  reset, asynchronous, active-low.
  pkt_vld_i  input  1  packet command valid.
  pkt_rdy_o  output  1  packet command ready.
  pkt_dst_row_i  input  ROW_ADDR_W  destination row.
  pkt_dst_col_i  input  COL_ADDR_W  destination column.
  pkt_len_i  input  LEN_W  payload flit count.
  pld_data_i  input  FLIT_DATA_W  payload word.
  pld_vld_i  input  1  payload valid.
  pld_rdy_o  output  1  payload ready.
  och_data_o  output  CHANNEL_W  flit to the NoC terminal input channel.
  och_vld_o  output  1  flit valid.
  och_rdy_i  input  1  NoC terminal ready.
  err_o  output  1  illegal-command pulse.

Function
REQ-008 SHALL format each flit as {id[FLIT_ID_W-1:0], data[FLIT_DATA_W-1:0]}, id in MSBs: HEAD=2'b10, BODY=2'b00, TAIL=2'b01; 2'b11 never emitted.
REQ-009 SHALL place the head flit's data as {zeros, dst_row, dst_col}, with dst_col in the LSBs.
REQ-010 SHALL use FSM states IDLE, HEAD, PLD.
REQ-011 In IDLE: pkt_rdy_o=1, pld_rdy_o=0, och_vld_o=0.
REQ-012 IDLE transition: on pkt_vld_i&pkt_rdy_o, latch destination and length, register the head flit, set och_vld_o=1 next cycle (1-cycle latency), and go to HEAD.
REQ-013 HEAD transition: hold the head flit until och_rdy_i=1, then go to PLD.
REQ-014 In PLD: pld_rdy_o = ~och_vld_o | och_rdy_i, using a single output register, so a payload word can be accepted in the same cycle a flit is sent.
REQ-015 In PLD: each accepted payload word is registered as BODY when remaining>1 and as TAIL when remaining==1; the remaining count decrements per accept.
REQ-016 SHALL send exactly pkt_len_i payload flits per packet; pkt_len_i=1 yields HEAD then TAIL with no BODY flits.
REQ-017 On the TAIL handshake (och_vld_o&och_rdy_i), SHALL return to IDLE; the next head flit appears no earlier than 2 cycles after the tail handshake.
REQ-018 While och_vld_o=1 and och_rdy_i=0, och_data_o SHALL remain stable and och_vld_o SHALL NOT deassert.
REQ-019 SHALL ignore pkt_vld_i outside IDLE, and SHALL ignore pld_vld_i outside PLD.
REQ-020 SHALL allow a destination equal to the local node; the network routes it to the TERM port.
REQ-021 err_o SHALL be 0 whenever the feature of REQ-026 is compiled out.

Reset
REQ-022 On rst_ni=0, SHALL immediately set state=IDLE, och_vld_o=0, och_data_o=0, pld_rdy_o=0, err_o=0, and clear the remaining count and the latched destination.
REQ-023 pkt_rdy_o SHALL read 1 from the first cycle after rst_ni deasserts.
REQ-024 A reset mid-packet SHALL abandon the packet without emitting a TAIL; network recovery is a system-level reset concern.
REQ-025 SHALL require no synchronous clear.

Configuration
REQ-026 Macro PACKETIZER_CMD_CHECK_EN: when defined, a command with pkt_dst_row_i>=ROW_N, pkt_dst_col_i>=COL_M or pkt_len_i==0 SHALL be consumed in IDLE, emit no flits, pulse err_o high for one cycle, and keep the FSM in IDLE.
REQ-027 Without PACKETIZER_CMD_CHECK_EN, SHALL forward the destination unchecked and treat pkt_len_i==0 as 1; err_o is tied to 0.

Verification (ROW_N=3, COL_M=3, CHANNEL_W=8)
REQ-028 Command dst(2,1), len 3, payloads 0x05/0x06/0x07, och_rdy_i=1 -> flits 0x89, 0x05, 0x06, 0x47 on consecutive cycles; pkt_rdy_o returns to 1 after the tail.
REQ-029 Command dst(0,0), len 1, payload 0x3F -> flits 0x80 then 0x7F.
REQ-030 och_rdy_i=0 for 3 cycles while BODY 0x05 is valid -> och_data_o holds 0x05, pld_rdy_o=0, and no flit is lost or duplicated.
REQ-031 With the macro, dst(3,0) len 2 -> err_o pulses once, och_vld_o stays 0. Without the macro, the same command -> head flit 0x8C, then 2 payload flits.
REQ-032 Assert rst_ni=0 after the head handshake -> och_vld_o=0 in the same cycle, FSM in IDLE; a new command then produces a correct head flit.
REQ-033 Two back-to-back commands -> flit order is HEAD, BODY*, TAIL per packet, with no interleaving across packets.

Source files
------------

// File: rtl/mesh_wormhole_packetizer.sv
// mesh_wormhole_packetizer: turns a (dst, len) command plus payload words into HEAD/BODY/TAIL wormhole flits.
// Optional command checking is enabled by defining PACKETIZER_CMD_CHECK_EN.
module mesh_wormhole_packetizer #(
  parameter int ROW_N = 3,
  parameter int COL_M = 3,
  parameter int CHANNEL_W = 8,
  parameter int FLIT_ID_W = 2,
  parameter int LEN_W = 4,
  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W,
  localparam int ROW_ADDR_W = $clog2(ROW_N),
  localparam int COL_ADDR_W = $clog2(COL_M)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pkt_vld_i,
  output logic                   pkt_rdy_o,
  input  logic [ROW_ADDR_W-1:0]  pkt_dst_row_i,
  input  logic [COL_ADDR_W-1:0]  pkt_dst_col_i,
  input  logic [LEN_W-1:0]       pkt_len_i,
  input  logic [FLIT_DATA_W-1:0] pld_data_i,
  input  logic                   pld_vld_i,
  output logic                   pld_rdy_o,
  output logic [CHANNEL_W-1:0]   och_data_o,
  output logic                   och_vld_o,
  input  logic                   och_rdy_i,
  output logic                   err_o
);
  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(0);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(1);
  typedef enum logic [1:0] {IDLE, HEAD, PLD} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CHANNEL_W-1:0] data_d;
  logic vld_d, err_q, err_d, bad, cmd_acc, pld_acc, tail_fire;
`ifdef PACKETIZER_CMD_CHECK_EN
  assign bad = (int'(pkt_dst_row_i) >= ROW_N) || (int'(pkt_dst_col_i) >= COL_M) || (pkt_len_i == '0);
`else
  assign bad = 1'b0;
`endif
  assign pkt_rdy_o = state_q == IDLE;
  // rem_q==0 means the tail is already registered, so no further payload may enter
  assign pld_rdy_o = (state_q == PLD) && (rem_q != '0) && (!och_vld_o || och_rdy_i);
  assign cmd_acc = pkt_vld_i && pkt_rdy_o;
  assign pld_acc = pld_vld_i && pld_rdy_o;
  assign tail_fire = och_vld_o && och_rdy_i && (och_data_o[CHANNEL_W-1 -: FLIT_ID_W] == ID_TAIL);
  assign err_o = err_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    data_d = och_data_o;
    vld_d = och_vld_o && !och_rdy_i;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (cmd_acc) begin
        err_d = bad;
        if (!bad) begin
          state_d = HEAD;
          rem_d = (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
          data_d = {ID_HEAD, FLIT_DATA_W'({pkt_dst_row_i, pkt_dst_col_i})};
          vld_d = 1'b1;
        end
      end
      HEAD: state_d = och_rdy_i ? PLD : HEAD;
      PLD: begin
        state_d = tail_fire ? IDLE : PLD;
        if (pld_acc) begin
          data_d = {(rem_q == LEN_W'(1)) ? ID_TAIL : ID_BODY, pld_data_i};
          vld_d = 1'b1;
          rem_d = rem_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q <= '0;
      och_data_o <= '0;
      och_vld_o <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      och_data_o <= data_d;
      och_vld_o <= vld_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mesh_wormhole_packetizer.sv
// tb_mesh_wormhole_packetizer: directed plus randomized flit-stream checks against a queue-based packet model.
module tb_mesh_wormhole_packetizer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pkt_vld = 1'b0, pkt_rdy, pld_vld = 1'b0, pld_rdy, och_vld, och_rdy = 1'b1, err;
  logic [1:0] pkt_row = '0, pkt_col = '0;
  logic [3:0] pkt_len = '0;
  logic [5:0] pld_data = '0;
  logic [7:0] och_data;
  int checks = 0, errors = 0;
  logic [7:0] got[$], exp_q[$];
  logic bp_en = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [7:0] prev_data = '0;

  mesh_wormhole_packetizer #(.ROW_N(3), .COL_M(3), .CHANNEL_W(8), .FLIT_ID_W(2), .LEN_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pkt_vld_i(pkt_vld), .pkt_rdy_o(pkt_rdy),
    .pkt_dst_row_i(pkt_row), .pkt_dst_col_i(pkt_col), .pkt_len_i(pkt_len),
    .pld_data_i(pld_data), .pld_vld_i(pld_vld), .pld_rdy_o(pld_rdy),
    .och_data_o(och_data), .och_vld_o(och_vld), .och_rdy_i(och_rdy), .err_o(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A flit seen valid+ready at the negedge completes its handshake on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (och_vld && och_rdy) got.push_back(och_data);
      if (och_vld) chk("legal_id", 32'(och_data[7:6] == 2'b11), 0);
      if (prev_vld && !prev_rdy) begin
        chk("stall_hold_vld", och_vld, 1);
        chk("stall_hold_data", och_data, prev_data);
      end
      if (och_vld && !och_rdy) chk("stall_pld_rdy", pld_rdy, 0);
    end
    prev_vld = rst_n && och_vld;
    prev_rdy = och_rdy;
    prev_data = och_data;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 och_rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input int row, input int col, input int len, input int base, input bit bad);
    int n = (len == 0) ? 1 : len;
    int idx = 0, t = 0;
    logic [5:0] pl[$];
    @(posedge clk);
    #1;
    pkt_vld = 1'b1; pkt_row = 2'(row); pkt_col = 2'(col); pkt_len = 4'(len);
    pld_vld = 1'b1; pld_data = 6'h2A;
    @(negedge clk);
    while (!pkt_rdy && t < 500) begin @(negedge clk); t++; end
    chk("cmd_accept", pkt_rdy, 1);
    @(posedge clk);
    #1;
    pkt_vld = 1'b0; pld_vld = 1'b0;
    @(negedge clk);
    if (bad) begin
      chk("err_pulse", err, 1);
      chk("err_no_flit", och_vld, 0);
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk("err_stay_idle", pkt_rdy, 1);
      chk("err_still_no_flit", och_vld, 0);
      return;
    end
    chk("head_latency_vld", och_vld, 1);
    chk("head_latency_data", och_data, 32'(8'h80 + 8'(row * 4 + col)));
    chk("no_err", err, 0);
    exp_q.push_back(8'h80 + 8'(row * 4 + col));
    for (int i = 0; i < n; i++) begin
      pl.push_back(base < 0 ? 6'($urandom) : 6'(base + i));
      exp_q.push_back(((i == n - 1) ? 8'h40 : 8'h00) + {2'b00, pl[i]});
    end
    t = 0;
    while (idx < n && t < 2000) begin
      @(posedge clk);
      #1;
      pkt_vld = 1'($urandom_range(0, 1)); pkt_row = 2'($urandom); pkt_col = 2'($urandom); pkt_len = 4'($urandom);
      pld_vld = ($urandom_range(0, 3) != 0);
      pld_data = pl[idx];
      @(negedge clk);
      if (pld_vld && pld_rdy) idx++;
      t++;
    end
    chk("payload_accepted", idx, n);
    @(posedge clk);
    #1;
    pkt_vld = 1'b0; pld_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (got.size() < exp_q.size() && t < 2000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_flit%0d", tag, i), (i < got.size()) ? 32'(got[i]) : {32{1'bx}}, 32'(exp_q[i]));
    chk({tag, "_pkt_rdy"}, pkt_rdy, 1);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_vld", och_vld, 0);
    chk("rst_data", och_data, 0);
    chk("rst_pld_rdy", pld_rdy, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pkt_rdy", pkt_rdy, 1);
    send(2, 1, 3, 5, 0);
    drain("d21_len3");
    send(0, 0, 1, 'h3F, 0);
    drain("d00_len1");
`ifdef PACKETIZER_CMD_CHECK_EN
    send(3, 0, 2, -1, 1);
    send(0, 3, 2, -1, 1);
    send(1, 1, 0, -1, 1);
    drain("bad_cmds");
`else
    send(3, 0, 2, -1, 0);
    drain("d30_unchecked");
    send(1, 1, 0, -1, 0);
    drain("len0_as_1");
`endif
    bp_en = 1'b1;
    send(1, 2, 4, 5, 0);
    drain("stalled");
    for (int k = 0; k < 10; k++) begin
      send($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 6), -1, 0);
      send($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 6), -1, 0);
      drain($sformatf("pair%0d", k));
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    pkt_vld = 1'b1; pkt_row = 2'd1; pkt_col = 2'd2; pkt_len = 4'd4;
    @(negedge clk);
    @(posedge clk);
    #1 pkt_vld = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(och_vld && och_rdy) && t < 50);
    chk("mid_rst_head_seen", och_vld && och_rdy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", och_vld, 0);
    chk("mid_rst_data", och_data, 0);
    chk("mid_rst_idle", pkt_rdy, 1);
    @(negedge clk);
    got.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_pkt_rdy", pkt_rdy, 1);
    send(2, 2, 2, 'h11, 0);
    drain("after_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
